serial_comparer: RTL and testbench

- Multi-cycle, parametrised successor to the single-cycle branch comparer.
- Compares two N-bit operands W bits per cycle, most significant chunk first, and terminates early on the first differing chunk.
- Uses a valid/ready handshake on both input and output, so it can sit behind the execute-stage operand latch or inside a narrow-datapath core variant where a full-width magnitude comparator is too large.

---
 rtl/serial_comparer.sv | 90 +++++++++
 tb/tb_serial_comparer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_comparer.sv
// serial_comparer: chunk-serial MSB-first magnitude/equality comparer with early exit and valid/ready handshakes.
module serial_comparer #(
  parameter int N = 32,
  parameter int W = 8,
  localparam int NC = N / W,
  localparam int CW = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   type_,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out,
  output logic         out_early
);
  localparam logic [2:0] CMP_EQ   = 3'd0;
  localparam logic [2:0] CMP_NE   = 3'd1;
  localparam logic [2:0] CMP_LT2  = 3'd2;
  localparam logic [2:0] CMP_LTU2 = 3'd3;
  localparam logic [2:0] CMP_LT   = 3'd4;
  localparam logic [2:0] CMP_GE   = 3'd5;
  localparam logic [2:0] CMP_LTU  = 3'd6;
  localparam logic [2:0] CMP_GEU  = 3'd7;
  localparam logic [CW-1:0] LAST = CW'(NC - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] idx, k;
  logic [N-1:0] a_r, b_r;
  logic [2:0] t_r;
  logic [W-1:0] ca, cb, flip;
  logic sgn, last, eq, lt, res, done_c;
  always_comb begin
    k = LAST - idx;
    sgn = t_r == CMP_LT || t_r == CMP_LT2 || t_r == CMP_GE;
    last = idx == LAST;
    // signed compare reduces to unsigned once the sign bits are inverted in the top chunk
    flip = (sgn && idx == '0) ? {1'b1, {(W-1){1'b0}}} : '0;
    ca = a_r[int'(k)*W +: W] ^ flip;
    cb = b_r[int'(k)*W +: W] ^ flip;
    eq = ca == cb;
    lt = ca < cb;
    done_c = !eq || last;
    res = t_r == CMP_EQ ? eq :
          t_r == CMP_NE ? !eq :
          (t_r == CMP_GE || t_r == CMP_GEU) ? !lt : lt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (state == IDLE) state_nx = in_valid ? RUN : IDLE;
    else if (state == RUN) state_nx = done_c ? DONE : RUN;
    else if (state == DONE) state_nx = out_ready ? IDLE : DONE;
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      out <= 1'b0;
      out_early <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      t_r <= '0;
    end else if (!flush) begin
      if (state == IDLE && in_valid) begin
        a_r <= in1;
        b_r <= in2;
        t_r <= type_;
        idx <= '0;
      end else if (state == RUN) begin
        if (done_c) begin
          out <= res;
          out_early <= !eq && !last;
        end else idx <= idx + 1'b1;
      end
    end
  a_handshake: assert property (@(posedge clk) disable iff (!rst_n) !(out_valid && in_ready));
  a_stable: assert property (@(posedge clk) disable iff (!rst_n) out_valid && !out_ready |=> $stable(out));
  a_ready: assert property (@(posedge clk) disable iff (!rst_n) in_ready == (state == IDLE));
endmodule

// File: tb/tb_serial_comparer.sv
// tb_serial_comparer: directed vector table plus handshake/flush/reset sequences and a randomised 64-bit sweep.
module tb_serial_comparer;
  localparam logic [2:0] EQ = 0, NE = 1, LT2 = 2, LTU2 = 3, LT = 4, GE = 5, LTU = 6, GEU = 7;
  logic clk = 0, rst_n = 0, flush = 0;
  always #5 clk = ~clk;
  logic iv = 0, ordy = 0, ir, ov, o, oe;
  logic [2:0] ty = 0;
  logic [31:0] i1 = 0, i2 = 0;
  logic iv16 = 0, ordy16 = 0, ir16, ov16, o16, oe16;
  logic [2:0] ty16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic iv64 = 0, ordy64 = 0, ir64, ov64, o64, oe64;
  logic [2:0] ty64 = 0;
  logic [63:0] a64 = 0, b64 = 0;
  serial_comparer #(.N(32), .W(8)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv), .in_ready(ir),
    .type_(ty), .in1(i1), .in2(i2), .out_valid(ov), .out_ready(ordy), .out(o), .out_early(oe));
  serial_comparer #(.N(16), .W(16)) u16 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv16), .in_ready(ir16),
    .type_(ty16), .in1(a16), .in2(b16), .out_valid(ov16), .out_ready(ordy16), .out(o16), .out_early(oe16));
  serial_comparer #(.N(64), .W(8)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv64), .in_ready(ir64),
    .type_(ty64), .in1(a64), .in2(b64), .out_valid(ov64), .out_ready(ordy64), .out(o64), .out_early(oe64));
  int pass = 0, total = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  typedef struct {logic [2:0] t; logic [31:0] a, b; logic o, e; int lat;} vec_t;
  vec_t vt[13];
  task automatic req32(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    chk("ready_before_req", ir, 1);
    iv = 1; ty = t; i1 = a; i2 = b;
    @(posedge clk);
    #1 iv = 0; ty = ~t; i1 = ~a; i2 = b ^ 32'h5a5a5a5a;
    lat = 0;
    while (!ov && lat < 64) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic consume32;
    ordy = 1;
    @(posedge clk);
    #1 ordy = 0;
    chk("valid_after_consume", ov, 0);
    chk("idle_after_consume", ir, 1);
  endtask
  function automatic logic ref64(input logic [2:0] t, input logic [63:0] a, input logic [63:0] b);
    case (t)
      EQ: return a == b;
      NE: return a != b;
      LT, LT2: return $signed(a) < $signed(b);
      LTU, LTU2: return a < b;
      GE: return $signed(a) >= $signed(b);
      default: return a >= b;
    endcase
  endfunction
  initial begin
    int lat, seen;
    vt[0]  = '{EQ,   32'h12345678, 32'h12345678, 1, 0, 4};
    vt[1]  = '{NE,   32'h12345678, 32'h12345678, 0, 0, 4};
    vt[2]  = '{LT,   32'h80000000, 32'h00000001, 1, 1, 1};
    vt[3]  = '{LTU,  32'h80000000, 32'h00000001, 0, 1, 1};
    vt[4]  = '{GE,   32'h00000005, 32'h00000005, 1, 0, 4};
    vt[5]  = '{GE,   32'hFFFFFFFF, 32'h00000000, 0, 1, 1};
    vt[6]  = '{GEU,  32'hFFFFFFFF, 32'h00000000, 1, 1, 1};
    vt[7]  = '{LT2,  32'hFFFFFFFF, 32'h00000000, 1, 1, 1};
    vt[8]  = '{LTU2, 32'h00000001, 32'h00000002, 1, 0, 4};
    vt[9]  = '{NE,   32'h00000100, 32'h00000200, 1, 1, 3};
    vt[10] = '{EQ,   32'h00FF0000, 32'h00FE0000, 0, 1, 2};
    vt[11] = '{GE,   32'h7F000000, 32'h80000000, 1, 1, 1};
    vt[12] = '{LT,   32'hFFFFFFFE, 32'hFFFFFFFF, 1, 0, 4};
    #3;
    chk("rst_in_ready", ir, 1);
    chk("rst_out_valid", ov, 0);
    chk("rst_out", o, 0);
    chk("rst_out_early", oe, 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 13; i++) begin
      req32(vt[i].t, vt[i].a, vt[i].b, lat);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_out", i), o, vt[i].o);
      chk($sformatf("vec%0d_early", i), oe, vt[i].e);
      chk($sformatf("vec%0d_in_ready", i), ir, 0);
      consume32();
    end
    req32(LTU, 3, 4, lat);
    chk("bp_latency", lat, 4);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_valid_held", ov, 1);
      chk("bp_out_held", o, 1);
      chk("bp_in_ready_low", ir, 0);
    end
    consume32();
    @(negedge clk);
    iv = 1; ty = EQ; i1 = 0; i2 = 0;
    @(posedge clk);
    #1 iv = 0;
    @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    chk("flush_run_valid", ov, 0);
    chk("flush_run_ready", ir, 1);
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1 seen |= int'(ov);
    end
    chk("flush_no_result", seen, 0);
    req32(LT, 32'hFFFFFFFF, 0, lat);
    chk("post_flush_latency", lat, 1);
    chk("post_flush_out", o, 1);
    consume32();
    @(negedge clk);
    iv = 1; flush = 1; ty = EQ;
    @(posedge clk);
    #1 iv = 0; flush = 0;
    chk("flush_idle_no_accept", ir, 1);
    req32(GEU, 9, 2, lat);
    chk("done_flush_valid_before", ov, 1);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    chk("done_flush_drop", ov, 0);
    chk("done_flush_ready", ir, 1);
    req32(EQ, 1, 1, lat);
    chk("rst_mid_done_valid_before", ov, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", ov, 0);
    chk("async_rst_ready", ir, 1);
    chk("async_rst_out", o, 0);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    iv16 = 1; ty16 = LT; a16 = 16'h8000; b16 = 16'h7FFF;
    @(posedge clk);
    #1 iv16 = 0;
    lat = 0;
    while (!ov16 && lat < 64) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("n16_latency", lat, 1);
    chk("n16_out", o16, 1);
    chk("n16_early", oe16, 0);
    ordy16 = 1;
    @(posedge clk);
    #1 ordy16 = 0;
    chk("n16_idle", ir16, 1);
    for (int n = 0; n < 1000; n++) begin
      logic [63:0] ra, rb;
      int mode;
      ra = {$urandom, $urandom};
      mode = $urandom_range(0, 2);
      rb = mode == 0 ? ra : mode == 1 ? ra ^ (64'd1 << $urandom_range(0, 63)) : {$urandom, $urandom};
      @(negedge clk);
      iv64 = 1; ty64 = 3'($urandom_range(0, 7)); a64 = ra; b64 = rb;
      @(posedge clk);
      #1 iv64 = 0;
      lat = 0;
      while (!ov64 && lat < 64) begin
        @(posedge clk);
        #1 lat++;
      end
      chk($sformatf("rand%0d_t%0d_%h_%h", n, ty64, ra, rb), o64, ref64(ty64, ra, rb));
      ordy64 = 1;
      @(posedge clk);
      #1 ordy64 = 0;
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
